// File: rtl/cpu_pkg.sv
// Core-wide constants shared by fetch, decode and the control unit.
// Holds instruction width, the canonical NOP, opcode encodings and the fetch FSM states.
package cpu_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  function automatic logic [6:0] opcode_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of {pc, instr} with flush and occupancy count.
// Latency: a push is visible at the head the cycle after; no bypass.
// Backpressure: none internally; the producer must never push while full.
module fetch_buffer #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 96
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      push,
  input  logic [DATA_W-1:0]         push_dat,
  input  logic                      pop,
  input  logic                      flush,
  output logic [DATA_W-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  // Credit accounting upstream guarantees a slot for every response.
  assert property (@(posedge clk) disable iff (!arst_n) !(push && count == FULL_CNT));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues in-order imem reads, buffers and presents instructions to decode.
// Latency: first request 2 cycles after reset release; a response is visible to decode one cycle later.
// Backpressure: requests are credit-limited by in-flight plus buffered; decode stall holds the buffer head.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH        = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = '0,
  parameter int                  MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   arst_n,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [PC_WIDTH-1:0]    imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   if_id_valid,
  input  logic                   if_id_ready,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic [6:0]             if_id_opcode
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW:0] CREDITS = (CW + 1)'(MAX_OUTSTANDING);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

  fetch_state_e state_q, state_d;
  logic         boot_q;
  logic         run;

  logic [PC_WIDTH-1:0] pc_q, rsp_pc_q, redirect_tgt;
  logic [CW-1:0]       outstanding_q, outstanding_d, kill_cnt_q, occupancy;
  logic                req_hs, push, pop, buf_empty;
  logic [PC_WIDTH+INSTR_WIDTH-1:0] head_dat;

  // boot_q keeps BOOT alive for one full cycle after the first edge that sees reset released.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_BOOT;
      boot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: if (boot_q) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    run = (state_q == ST_RUN);
  end

  assign redirect_tgt   = redirect_pc & ALIGN_MASK;
  assign imem_req_valid = run && (({1'b0, outstanding_q} + {1'b0, occupancy}) < CREDITS);
  assign imem_req_addr  = pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && (kill_cnt_q == '0) && !redirect_valid;
  assign pop            = if_id_valid && if_id_ready;
  assign outstanding_d  = outstanding_q + CW'(req_hs) - CW'(imem_rsp_valid);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      kill_cnt_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        kill_cnt_q <= outstanding_d;
        pc_q       <= redirect_tgt;
        rsp_pc_q   <= redirect_tgt;
      end else begin
        if (req_hs) pc_q <= pc_q + PC_WIDTH'(4);
        if (imem_rsp_valid) begin
          if (kill_cnt_q != '0) kill_cnt_q <= kill_cnt_q - CW'(1);
          else                  rsp_pc_q   <= rsp_pc_q + PC_WIDTH'(4);
        end
      end
    end
  end

  fetch_buffer #(
    .DEPTH  (MAX_OUTSTANDING),
    .DATA_W (PC_WIDTH + INSTR_WIDTH)
  ) u_fetch_buffer (
    .clk      (clk),
    .arst_n   (arst_n),
    .push     (push),
    .push_dat ({rsp_pc_q, imem_rsp_data}),
    .pop      (pop),
    .flush    (redirect_valid),
    .head_dat (head_dat),
    .count    (occupancy),
    .empty    (buf_empty)
  );

  assign if_id_valid  = !buf_empty;
  assign if_id_instr  = buf_empty ? NOP_INSTR : head_dat[INSTR_WIDTH-1:0];
  assign if_id_pc     = buf_empty ? rsp_pc_q : head_dat[PC_WIDTH+INSTR_WIDTH-1:INSTR_WIDTH];
  assign if_id_opcode = opcode_of(if_id_instr);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: random memory/decode behaviour scored against an expected PC stream.
module tb_fetch_stage;

  localparam logic [63:0] RESET_PC_A = 64'h100;
  localparam logic [63:0] RESET_PC_W = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk, arst_n;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid;
  logic [63:0] imem_req_addr, redirect_pc, if_id_pc;
  logic [31:0] imem_rsp_data, if_id_instr;
  logic        if_id_valid, if_id_ready;
  logic [6:0]  if_id_opcode;

  logic        w_req_valid, w_rsp_valid, w_if_id_valid;
  logic [63:0] w_req_addr, w_if_id_pc;
  logic [31:0] w_rsp_data, w_if_id_instr;
  logic [6:0]  w_if_id_opcode;

  int checks = 0;
  int failures = 0;
  int cyc;
  int rdy_pct, rsp_pct, dec_pct;
  bit redir_req;
  logic [63:0] redir_tgt, exp_req, exp_dec, last_hs_addr, last_pop_pc;
  bit last_hs, last_pop, last_rsp;

  typedef struct {
    logic [63:0] addr;
    int          cyc;
  } mreq_t;
  mreq_t mq[$];

  fetch_stage #(.PC_WIDTH(64), .RESET_PC(RESET_PC_A), .MAX_OUTSTANDING(2)) u_dut (
    .clk(clk), .arst_n(arst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_ready(if_id_ready), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .if_id_opcode(if_id_opcode)
  );

  fetch_stage #(.PC_WIDTH(64), .RESET_PC(RESET_PC_W), .MAX_OUTSTANDING(2)) u_wrap (
    .clk(clk), .arst_n(arst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(1'b0), .redirect_pc(64'h0),
    .if_id_valid(w_if_id_valid), .if_id_ready(1'b1), .if_id_instr(w_if_id_instr),
    .if_id_pc(w_if_id_pc), .if_id_opcode(w_if_id_opcode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    logic [31:0] h;
    h = (a[31:0] ^ a[63:32]) * 32'h9E37_79B1;
    return h ^ {25'h0, a[8:2]};
  endfunction

  task automatic rst_assert();
    @(negedge clk);
    arst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_id_ready = 1'b0;
    w_rsp_valid = 1'b0; w_rsp_data = '0;
    mq.delete();
    exp_req = RESET_PC_A; exp_dec = RESET_PC_A;
    cyc = 0; redir_req = 1'b0;
    last_hs = 1'b0; last_pop = 1'b0; last_rsp = 1'b0;
  endtask

  task automatic do_reset();
    rst_assert();
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
  endtask

  // One cycle: memory model, random handshakes, and the in-order PC-stream scoreboard.
  task automatic tick();
    logic [31:0] exp_i;
    mreq_t       m;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; last_rsp = 1'b0;
    if (mq.size() != 0 && mq[0].cyc < cyc && $urandom_range(99) < rsp_pct) begin
      m = mq.pop_front();
      imem_rsp_valid = 1'b1; imem_rsp_data = instr_of(m.addr); last_rsp = 1'b1;
    end
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    if_id_ready    = ($urandom_range(99) < dec_pct);
    redirect_valid = redir_req;
    redirect_pc    = redir_tgt;

    last_hs = imem_req_valid && imem_req_ready;
    if (last_hs) begin
      checks++;
      if (imem_req_addr !== exp_req) begin
        failures++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_req);
      end
      mq.push_back('{addr: imem_req_addr, cyc: cyc});
      last_hs_addr = imem_req_addr;
      exp_req = exp_req + 64'd4;
    end
    last_pop = if_id_valid && if_id_ready;
    if (last_pop) begin
      exp_i = instr_of(exp_dec);
      checks++;
      if (if_id_pc !== exp_dec) begin
        failures++;
        $display("FAIL dec_pc cyc=%0d got=%h exp=%h", cyc, if_id_pc, exp_dec);
      end
      checks++;
      if (if_id_instr !== exp_i || if_id_opcode !== exp_i[6:0]) begin
        failures++;
        $display("FAIL dec_instr cyc=%0d got=%h/%h exp=%h/%h", cyc, if_id_instr, if_id_opcode, exp_i, exp_i[6:0]);
      end
      last_pop_pc = if_id_pc;
      exp_dec = exp_dec + 64'd4;
    end else if (!if_id_valid) begin
      checks++;
      if (if_id_instr !== NOP || if_id_opcode !== 7'b0010011) begin
        failures++;
        $display("FAIL empty_nop cyc=%0d got=%h/%h exp=%h", cyc, if_id_instr, if_id_opcode, NOP);
      end
    end
    if (redir_req) begin
      exp_req = redir_tgt & ~64'h3;
      exp_dec = redir_tgt & ~64'h3;
      redir_req = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int first_req, first_vld;
    rst_assert();
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC_A) begin
      failures++;
      $display("FAIL reset_req got=%b/%h exp=0/%h", imem_req_valid, imem_req_addr, RESET_PC_A);
    end
    checks++;
    if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== RESET_PC_A || if_id_opcode !== 7'h13) begin
      failures++;
      $display("FAIL reset_ifid got=%b/%h/%h/%h", if_id_valid, if_id_instr, if_id_pc, if_id_opcode);
    end
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    rdy_pct = 100; rsp_pct = 100; dec_pct = 100;
    first_req = -1; first_vld = -1;
    for (int k = 0; k < 12; k++) begin
      if (imem_req_valid && first_req < 0) first_req = k;
      if (if_id_valid && first_vld < 0) first_vld = k;
      tick();
    end
    checks++;
    if (first_req != 2) begin
      failures++;
      $display("FAIL first_req_cycle got=%0d exp=2", first_req);
    end
    checks++;
    if (first_vld != 4) begin
      failures++;
      $display("FAIL first_valid_cycle got=%0d exp=4", first_vld);
    end
    checks++;
    if (exp_dec - RESET_PC_A < 64'd12) begin
      failures++;
      $display("FAIL too_few_delivered got=%0d exp>=3", (exp_dec - RESET_PC_A) / 4);
    end
  endtask

  task automatic test_stall();
    int n_hs;
    logic [63:0] pops[$];
    do_reset();
    rdy_pct = 100; rsp_pct = 100; dec_pct = 0;
    n_hs = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (last_hs) n_hs++;
    end
    checks++;
    if (n_hs != 2 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_credit got=%0d reqs valid=%b exp=2 reqs valid=0", n_hs, imem_req_valid);
    end
    dec_pct = 100;
    for (int k = 0; k < 10 && pops.size() < 2; k++) begin
      tick();
      if (last_pop) pops.push_back(last_pop_pc);
    end
    checks++;
    if (pops.size() != 2 || pops[0] !== 64'h100 || pops[1] !== 64'h104) begin
      failures++;
      $display("FAIL stall_release got=%0d pops exp=2 pops 100,104", pops.size());
    end
  endtask

  task automatic test_redirect_kill();
    int n_hs;
    bit seen;
    do_reset();
    rdy_pct = 100; rsp_pct = 0; dec_pct = 100;
    tick();
    redir_req = 1'b1; redir_tgt = 64'h200;
    tick();
    n_hs = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (last_hs) n_hs++;
    end
    checks++;
    if (n_hs != 2 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL kill_setup got=%0d reqs exp=2", n_hs);
    end
    redir_req = 1'b1; redir_tgt = 64'h803;
    tick();
    checks++;
    if (imem_req_addr !== 64'h800 || if_id_valid !== 1'b0) begin
      failures++;
      $display("FAIL redirect_next got=%h/%b exp=800/0", imem_req_addr, if_id_valid);
    end
    rsp_pct = 100;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = last_pop;
    end
    checks++;
    if (!seen || last_pop_pc !== 64'h800) begin
      failures++;
      $display("FAIL redirect_first_pc got=%h seen=%b exp=800", last_pop_pc, seen);
    end
  endtask

  task automatic test_same_cycle();
    bit seen;
    do_reset();
    rdy_pct = 100; rsp_pct = 100; dec_pct = 100;
    repeat (3) tick();
    redir_req = 1'b1; redir_tgt = 64'h400;
    tick();
    checks++;
    if (!(last_hs && last_rsp)) begin
      failures++;
      $display("FAIL same_cycle_setup got hs=%b rsp=%b exp=1/1", last_hs, last_rsp);
    end
    checks++;
    if (imem_req_addr !== 64'h400 || if_id_valid !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_next got=%h/%b exp=400/0", imem_req_addr, if_id_valid);
    end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = last_pop;
    end
    checks++;
    if (!seen || last_pop_pc !== 64'h400) begin
      failures++;
      $display("FAIL same_cycle_first_pc got=%h seen=%b exp=400", last_pop_pc, seen);
    end
    repeat (20) tick();
  endtask

  task automatic test_random();
    int n_pop;
    do_reset();
    n_pop = 0;
    for (int k = 0; k < 1500; k++) begin
      if (k % 200 == 0) begin
        rdy_pct = $urandom_range(100, 30);
        rsp_pct = $urandom_range(100, 30);
        dec_pct = $urandom_range(100, 30);
      end
      if ($urandom_range(99) < 3) begin
        redir_req = 1'b1;
        redir_tgt = {$urandom, $urandom};
      end
      tick();
      if (last_pop) n_pop++;
    end
    checks++;
    if (n_pop < 50) begin
      failures++;
      $display("FAIL random_progress got=%0d pops exp>=50", n_pop);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    do_reset();
    rdy_pct = 100; rsp_pct = 100; dec_pct = 0;
    repeat (8) tick();
    checks++;
    if (if_id_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_before_reset got valid=%b req=%b exp=1/0", if_id_valid, imem_req_valid);
    end
    #2;
    arst_n = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC_A || if_id_valid !== 1'b0 ||
        if_id_instr !== NOP || if_id_pc !== RESET_PC_A || if_id_opcode !== 7'h13) begin
      failures++;
      $display("FAIL async_reset got=%b/%h/%b/%h/%h exp=0/100/0/13/100",
               imem_req_valid, imem_req_addr, if_id_valid, if_id_instr, if_id_pc);
    end
    do_reset();
    rdy_pct = 100; rsp_pct = 100; dec_pct = 100;
    seen = 1'b0;
    for (int k = 0; k < 15 && !seen; k++) begin
      tick();
      seen = last_pop;
    end
    checks++;
    if (!seen || last_pop_pc !== RESET_PC_A) begin
      failures++;
      $display("FAIL restart_pc got=%h seen=%b exp=%h", last_pop_pc, seen, RESET_PC_A);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] wq[$], w_reqs[$], w_pops[$];
    logic [63:0] a;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      w_rsp_valid = 1'b0; w_rsp_data = '0;
      if (wq.size() != 0) begin
        a = wq.pop_front();
        w_rsp_valid = 1'b1; w_rsp_data = instr_of(a);
      end
      if (w_req_valid) begin
        wq.push_back(w_req_addr);
        w_reqs.push_back(w_req_addr);
      end
      if (w_if_id_valid) begin
        w_pops.push_back(w_if_id_pc);
        checks++;
        if ($isunknown({w_if_id_pc, w_if_id_instr}) || w_if_id_instr !== instr_of(w_if_id_pc)) begin
          failures++;
          $display("FAIL wrap_instr got=%h pc=%h exp=%h", w_if_id_instr, w_if_id_pc, instr_of(w_if_id_pc));
        end
      end
      @(negedge clk);
    end
    w_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (w_reqs.size() <= i || w_reqs[i] !== RESET_PC_W + 64'(4 * i)) begin
        failures++;
        $display("FAIL wrap_req%0d got=%h exp=%h", i, (w_reqs.size() > i) ? w_reqs[i] : 64'hx, RESET_PC_W + 64'(4 * i));
      end
      checks++;
      if (w_pops.size() <= i || w_pops[i] !== RESET_PC_W + 64'(4 * i)) begin
        failures++;
        $display("FAIL wrap_pc%0d got=%h exp=%h", i, (w_pops.size() > i) ? w_pops[i] : 64'hx, RESET_PC_W + 64'(4 * i));
      end
    end
  endtask

  initial begin
    arst_n = 1'b1;
    rdy_pct = 100; rsp_pct = 100; dec_pct = 100;
    redir_tgt = '0;
    test_reset();
    test_stall();
    test_redirect_kill();
    test_same_cycle();
    test_async_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the RISC-V core, directly upstream of decode and the control unit. Owns the PC, issues in-order read requests to instruction memory over a valid/ready interface, buffers returned instructions, and presents them to decode with their PC and extracted `opcode[6:0]`. Branch and jump redirects from later stages flush the buffer and discard in-flight responses.

## Interface
Parameters:
- `PC_WIDTH`, 64: PC and address width.
- `RESET_PC`, 0: PC value after reset.
- `MAX_OUTSTANDING`, 2: maximum in-flight requests; also the buffer depth (power of two, ≥2).

Ports:
- `clk`  in  1: clock, rising edge.
- `arst_n`  in  1: asynchronous, active-low reset.
- `imem_req_valid`  out  1: fetch request valid.
- `imem_req_ready`  in  1: memory accepts request.
- `imem_req_addr`  out  PC_WIDTH: fetch address, always 4-byte aligned.
- `imem_rsp_valid`  in  1: response valid; responses are in order and always accepted.
- `imem_rsp_data`  in  32: instruction word.
- `redirect_valid`  in  1: branch/jump taken.
- `redirect_pc`  in  PC_WIDTH: target; bits [1:0] are forced to 0.
- `if_id_valid`  out  1: instruction available to decode.
- `if_id_ready`  in  1: decode accepts (deasserted on stall).
- `if_id_instr`  out  32: instruction word.
- `if_id_pc`  out  PC_WIDTH: PC of that instruction.
- `if_id_opcode`  out  7: `if_id_instr[6:0]`, wired to the control unit.

## Operation
- FSM states: BOOT (one cycle after reset release, no requests) → RUN (permanent). Reset from any state returns to BOOT.
- Credit rule: `imem_req_valid = (state==RUN) && (outstanding + occupancy < MAX_OUTSTANDING)`. Driven from registers only; there is no combinational path from `redirect_valid`, `imem_rsp_*`, or `if_id_ready`.
- A request handshake increments `outstanding`. `pc` advances by 4, mod 2^PC_WIDTH, with wrap-around permitted.
- Response: decrements `outstanding`. If `kill_cnt > 0`, the response is dropped and `kill_cnt` decrements. Otherwise {data, pc} is pushed into the buffer. The buffer PC comes from a separate response-PC register advanced per accepted response.
- Decode handshake (`if_id_valid && if_id_ready`) pops the buffer head. Push and pop in the same cycle are both performed; occupancy is unchanged.
- Redirect (highest priority):
  - Buffer is flushed.
  - `kill_cnt` is set to the number of requests in flight after this cycle's request and response handshakes.
  - `pc` and the response PC are both set to `{redirect_pc[PC_WIDTH-1:2],2'b00}`.
  - A request accepted in the same cycle counts as killed.
  - A same-cycle pop is harmless.
- The buffer can never overflow because of the credit rule; a push while full is an assertion failure.
- Empty buffer: `if_id_valid=0` and `if_id_instr` = NOP `32'h00000013`, so `if_id_opcode=7'b0010011`.

## Timing
- Reset values:
  - state BOOT, `pc=RESET_PC`, `outstanding=0`, `kill_cnt=0`, buffer empty.
  - `imem_req_valid=0`, `imem_req_addr=RESET_PC`.
  - `if_id_valid=0`, `if_id_instr=32'h00000013`, `if_id_pc=RESET_PC`.
- First `imem_req_valid` is asserted 2 cycles after `arst_n` deasserts (synchronously observed).
- Response at cycle N gives `if_id_valid` at N+1 (registered buffer, no bypass).
- Redirect at cycle N:
  - `imem_req_addr=target` at N+1.
  - `if_id_valid=0` at N+1.
  - The first target instruction is visible one cycle after its response.
- Zero-latency memory with decode always ready sustains 1 instruction/cycle once `MAX_OUTSTANDING ≥ 2`.
- Asynchronous reset mid-transfer clears all state immediately. Memory-side responses still in flight across reset are the memory's responsibility, which requires memory reset in the same domain.

## Structure
- The shared `cpu_pkg` holds `NOP_INSTR`, the opcode constants (shared with the control unit), and `INSTR_WIDTH=32`.
- Sub-module `fetch_buffer`: synchronous FIFO of {pc, instr}, with depth `MAX_OUTSTANDING`, push/pop/flush, and count output.
- `kill_cnt` and `outstanding` are each `$clog2(MAX_OUTSTANDING)+1` bits wide.

## Test plan
- Reset, `RESET_PC=0x100`, memory always ready, 1-cycle latency, decode ready → expected output:
  - `if_id_pc` sequence 0x100, 0x104, 0x108.
  - First `if_id_valid` is asserted 4 cycles after reset release.
  - Opcode matches `instr[6:0]`.
- Decode `if_id_ready=0` for 10 cycles:
  - Exactly 2 requests issue, then `imem_req_valid=0`.
  - On release, 0x100 and 0x104 are delivered in order with no loss.
- Two requests in flight (0x200, 0x204) and redirect to 0x803:
  - Both responses are dropped.
  - Next request address is 0x800.
  - The first `if_id_pc` after the redirect is 0x800.
- Redirect in the same cycle as a response and a request handshake:
  - The response and both in-flight requests are killed.
  - No stale instruction reaches decode.
- `RESET_PC=2^64-8`:
  - Requests go to …F8, …FC, 0x0.
  - PCs are delivered with wrap and no X.
- `arst_n` asserted mid-stream with a full buffer:
  - All outputs take their reset values in the same cycle.
  - After release, fetch restarts from `RESET_PC`.
